// File: rtl/serial_pair_serializer_msb_first.sv
// serial_pair_serializer_msb_first
//   Accepts a pair of W-bit words (A, B) on a valid/ready handshake and emits
//   them one bit per beat, MSB first, on a/b. first/last flag the MSB and LSB
//   beats so a downstream serial comparator can restart per word.
//   Backpressure holds the current beat. Back-to-back words stream with no
//   bubble.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous reset, active-low
//   in_valid   in_a/in_b hold a word to accept
//   in_ready   block can accept a word this cycle (combinational on last beat)
//   in_a/in_b  W-bit words, bit W-1 is the MSB
//   bit_valid  a/b/first/last carry a valid beat
//   out_ready  downstream consumes the current beat
//   a/b        current bit of A/B
//   first      current beat is the MSB of its word
//   last       current beat is the LSB of its word
module serial_pair_serializer_msb_first #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_a,
  input  logic [W-1:0] in_b,
  output logic         bit_valid,
  input  logic         out_ready,
  output logic         a,
  output logic         b,
  output logic         first,
  output logic         last
);

  localparam int unsigned CW = (W > 1) ? $clog2(W) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(W - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t        state, state_nx;
  logic [W-1:0]  sh_a, sh_a_nx;
  logic [W-1:0]  sh_b, sh_b_nx;
  logic [CW-1:0] cnt, cnt_nx;

  // State and datapath registers; reset drops any word in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      sh_a  <= '0;
      sh_b  <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      sh_a  <= sh_a_nx;
      sh_b  <= sh_b_nx;
      cnt   <= cnt_nx;
    end
  end

  // Next-state, datapath update and beat outputs.
  always_comb begin
    state_nx  = state;
    sh_a_nx   = sh_a;
    sh_b_nx   = sh_b;
    cnt_nx    = cnt;
    in_ready  = 1'b0;
    bit_valid = 1'b0;
    a         = 1'b0;
    b         = 1'b0;
    first     = 1'b0;
    last      = 1'b0;

    case (state)
      IDLE: begin
        // rst gating keeps in_ready low while reset is held.
        in_ready = rst;
        if (in_valid) begin
          sh_a_nx  = in_a;
          sh_b_nx  = in_b;
          cnt_nx   = CNT_MAX;
          state_nx = SHIFT;
        end
      end

      SHIFT: begin
        bit_valid = 1'b1;
        a         = sh_a[W-1];
        b         = sh_b[W-1];
        first     = (cnt == CNT_MAX);
        last      = (cnt == '0);
        // Only the final beat, when it is consumed, frees the block.
        in_ready  = rst & last & out_ready;
        if (out_ready) begin
          if (cnt != '0) begin
            sh_a_nx = W'(sh_a << 1);
            sh_b_nx = W'(sh_b << 1);
            cnt_nx  = cnt - CW'(1);
          end else if (in_valid) begin
            // Reload on the last beat for zero-bubble streaming.
            sh_a_nx = in_a;
            sh_b_nx = in_b;
            cnt_nx  = CNT_MAX;
          end else begin
            state_nx = IDLE;
          end
        end
      end

      default: state_nx = IDLE;
    endcase
  end

endmodule
